// File: rtl/writeback_scoreboard.sv
// writeback_scoreboard
//   Per-register in-flight counters for non-forwardable producers (loads,
//   multi-cycle mul/div). ID issue increments, WB retirement decrements, and a
//   combinational stall holds any consumer whose source still has an
//   outstanding tracked write. A retiring write in WB counts as resolved, so
//   it does not stall the consumer. Issue is also held when the destination
//   counter is already full.
//   Optional feature macro: SCOREBOARD_STATS_EN builds a saturating 16-bit
//   stall-cycle counter. Without it, stall_count is tied to zero.
module writeback_scoreboard #(
  parameter int NREGS    = 32,
  parameter int CNT_W    = 2,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_valid,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_rs_used,
  input  logic             ID_rt_used,
  input  logic [4:0]       ID_rd,
  input  logic             ID_RegWrite,
  input  logic             ID_Track,
  input  logic [4:0]       WB_rd,
  input  logic             WB_RegWrite,
  input  logic             WB_Track,
  output logic             stall,
  output logic [NREGS-1:0] pending,
  output logic             sb_err,
  output logic [15:0]      stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [4:0]       ZERO_SPEC = 5'(ZERO_REG);

  logic [CNT_W-1:0] count_q [NREGS];
  logic [CNT_W-1:0] count_d [NREGS];
  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic             sb_err_q;
  logic             sb_err_d;

  logic [NREGS-1:0] inc;
  logic [NREGS-1:0] dec;
  logic             hz_rs;
  logic             hz_rt;
  logic             sat_hz;
  logic             issue;

  // Decode which register a tracked writeback retires this cycle.
  always_comb begin
    dec = '0;
    for (int r = 0; r < NREGS; r++) begin
      dec[r] = WB_RegWrite && WB_Track && (WB_rd == 5'(r)) && (r != ZERO_REG);
    end
  end

  // Source and saturation hazards; a final write retiring in WB does not stall.
  always_comb begin
    hz_rs  = ID_rs_used && (ID_rs != ZERO_SPEC) && (count_q[ID_rs] != CNT_ZERO)
             && !((count_q[ID_rs] == CNT_ONE) && dec[ID_rs]);
    hz_rt  = ID_rt_used && (ID_rt != ZERO_SPEC) && (count_q[ID_rt] != CNT_ZERO)
             && !((count_q[ID_rt] == CNT_ONE) && dec[ID_rt]);
    sat_hz = ID_RegWrite && ID_Track && (ID_rd != ZERO_SPEC)
             && (count_q[ID_rd] == CNT_MAX) && !dec[ID_rd];
    stall  = ID_valid && (hz_rs || hz_rt || sat_hz);
    issue  = ID_valid && !stall;
  end

  // Decode which register an issuing tracked producer claims this cycle.
  always_comb begin
    inc = '0;
    for (int r = 0; r < NREGS; r++) begin
      inc[r] = issue && ID_RegWrite && ID_Track && (ID_rd == 5'(r)) && (r != ZERO_REG);
    end
  end

  // Counter next state; underflow and overflow hold the count and flag an error.
  always_comb begin
    sb_err_d  = sb_err_q;
    pending_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      count_d[r] = count_q[r];
      if (inc[r] && !dec[r]) begin
        if (count_q[r] == CNT_MAX) begin
          sb_err_d = 1'b1;
        end else begin
          count_d[r] = count_q[r] + CNT_ONE;
        end
      end else if (dec[r] && !inc[r]) begin
        if (count_q[r] == CNT_ZERO) begin
          sb_err_d = 1'b1;
        end else begin
          count_d[r] = count_q[r] - CNT_ONE;
        end
      end else begin
        count_d[r] = count_q[r];
      end
      pending_d[r] = (count_d[r] != CNT_ZERO);
    end
  end

  // Tracking state: counters, pending mirror and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        count_q[r] <= CNT_ZERO;
      end
      pending_q <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        count_q[r] <= count_d[r];
      end
      pending_q <= pending_d;
      sb_err_q  <= sb_err_d;
    end
  end

  assign pending = pending_q;
  assign sb_err  = sb_err_q;

`ifdef SCOREBOARD_STATS_EN
  logic [15:0] stall_count_q;
  logic [15:0] stall_count_d;

  // Saturating count of cycles in which ID was held.
  always_comb begin
    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Stall statistics register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= 16'h0000;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Testbench for writeback_scoreboard: directed scenarios followed by random
// traffic. The driver pushes expected outputs into a queue from a reference
// model; a separate monitor pops and compares once per cycle.
module tb_writeback_scoreboard;

  localparam int MAXC = 3;
  localparam int ZR   = 31;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ID_valid, ID_rs_used, ID_rt_used, ID_RegWrite, ID_Track;
  logic [4:0]  ID_rs, ID_rt, ID_rd, WB_rd;
  logic        WB_RegWrite, WB_Track;
  logic        stall;
  logic [31:0] pending;
  logic        sb_err;
  logic [15:0] stall_count;

  typedef struct {
    logic        st;
    logic [31:0] pend;
    logic        err;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];
  int   cnt [32];
  bit   err_m;
  int   sc_m;
  int   total = 0;
  int   bad   = 0;

`ifdef SCOREBOARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  writeback_scoreboard dut (
    .clk(clk), .rst(rst),
    .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used),
    .ID_rd(ID_rd), .ID_RegWrite(ID_RegWrite), .ID_Track(ID_Track),
    .WB_rd(WB_rd), .WB_RegWrite(WB_RegWrite), .WB_Track(WB_Track),
    .stall(stall), .pending(pending), .sb_err(sb_err), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Number of tracked writes to register s that retire in WB this cycle.
  function automatic int retiring(input int s);
    return (WB_RegWrite && WB_Track && int'(WB_rd) == s && s != ZR) ? 1 : 0;
  endfunction

  // A source must wait while writes remain outstanding after this cycle's retirement.
  function automatic bit src_wait(input bit used, input int s);
    return used && s != ZR && (cnt[s] - retiring(s)) > 0;
  endfunction

  function automatic bit model_stall();
    bit full;
    full = ID_RegWrite && ID_Track && int'(ID_rd) != ZR
           && (cnt[int'(ID_rd)] - retiring(int'(ID_rd))) >= MAXC;
    return ID_valid && (src_wait(ID_rs_used, int'(ID_rs)) ||
                        src_wait(ID_rt_used, int'(ID_rt)) || full);
  endfunction

  function automatic logic [31:0] pend_m();
    logic [31:0] p;
    p = 32'h0;
    for (int r = 0; r < 32; r++) p[r] = (cnt[r] != 0);
    return p;
  endfunction

  // Record what the DUT must show this cycle, then advance the model over the edge.
  task automatic step();
    exp_t e;
    bit   sv;
    int   nw, nr;
    if (rst) begin
      for (int r = 0; r < 32; r++) cnt[r] = 0;
      err_m = 1'b0;
      sc_m  = 0;
      e.st = 1'b0; e.pend = 32'h0; e.err = 1'b0; e.sc = 16'h0;
      q.push_back(e);
      return;
    end
    sv = model_stall();
    e.st = sv; e.pend = pend_m(); e.err = err_m; e.sc = 16'(sc_m);
    q.push_back(e);
    nw = (ID_valid && !sv && ID_RegWrite && ID_Track && int'(ID_rd) != ZR) ? int'(ID_rd) : -1;
    nr = (retiring(int'(WB_rd)) == 1) ? int'(WB_rd) : -1;
    if (nw != nr) begin
      if (nw >= 0) begin
        if (cnt[nw] == MAXC) err_m = 1'b1; else cnt[nw] = cnt[nw] + 1;
      end
      if (nr >= 0) begin
        if (cnt[nr] == 0) err_m = 1'b1; else cnt[nr] = cnt[nr] - 1;
      end
    end
    if (STATS && sv && sc_m < 65535) sc_m = sc_m + 1;
  endtask

  task automatic nxt();
    @(negedge clk);
    ID_valid = 1'b0; ID_rs = 5'd0; ID_rt = 5'd0; ID_rs_used = 1'b0; ID_rt_used = 1'b0;
    ID_rd = 5'd0; ID_RegWrite = 1'b0; ID_Track = 1'b0;
    WB_rd = 5'd0; WB_RegWrite = 1'b0; WB_Track = 1'b0;
  endtask

  task automatic prod(input int rd);
    ID_valid = 1'b1; ID_rd = 5'(rd); ID_RegWrite = 1'b1; ID_Track = 1'b1;
  endtask

  task automatic cons(input int rs);
    ID_valid = 1'b1; ID_rs = 5'(rs); ID_rs_used = 1'b1;
  endtask

  task automatic wb(input int rd);
    WB_rd = 5'(rd); WB_RegWrite = 1'b1; WB_Track = 1'b1;
  endtask

  function automatic int pick();
    int v;
    v = ($urandom_range(0, 9) == 9) ? ZR : int'($urandom_range(0, 7));
    return v;
  endfunction

  // Monitor: compare DUT outputs with the oldest expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (stall !== e.st) begin
          bad++; $display("FAIL stall got=%0b exp=%0b t=%0t", stall, e.st, $time);
        end
        total++;
        if (pending !== e.pend) begin
          bad++; $display("FAIL pending got=%h exp=%h t=%0t", pending, e.pend, $time);
        end
        total++;
        if (sb_err !== e.err) begin
          bad++; $display("FAIL sb_err got=%0b exp=%0b t=%0t", sb_err, e.err, $time);
        end
        total++;
        if (stall_count !== e.sc) begin
          bad++; $display("FAIL stall_count got=%0d exp=%0d t=%0t", stall_count, e.sc, $time);
        end
      end
    end
  end

  // Driver: directed scenarios, then random traffic.
  initial begin
    ID_valid = 1'b0; ID_rs = 5'd0; ID_rt = 5'd0; ID_rs_used = 1'b0; ID_rt_used = 1'b0;
    ID_rd = 5'd0; ID_RegWrite = 1'b0; ID_Track = 1'b0;
    WB_rd = 5'd0; WB_RegWrite = 1'b0; WB_Track = 1'b0;
    for (int r = 0; r < 32; r++) cnt[r] = 0;
    err_m = 1'b0; sc_m = 0;

    // Reset with a would-be hazard on the ID inputs.
    rst = 1'b1;
    nxt(); cons(5); step();
    nxt(); rst = 1'b0; step();

    // 1: tracked producer then dependent consumer.
    nxt(); prod(5); step();
    nxt(); cons(5); step();
    nxt(); cons(5); step();
    // 2: final retirement bypasses the stall.
    nxt(); cons(5); wb(5); step();
    nxt(); step();

    // 3: saturate rd=7, fourth issue held, then retire while held.
    for (int i = 0; i < 4; i++) begin nxt(); prod(7); step(); end
    nxt(); prod(7); step();
    nxt(); prod(7); wb(7); step();
    for (int i = 0; i < 3; i++) begin nxt(); cons(7); wb(7); step(); end
    nxt(); step();

    // 4: simultaneous inc and dec on rd=9.
    nxt(); prod(9); step();
    nxt(); prod(9); wb(9); step();
    nxt(); step();
    nxt(); wb(9); step();

    // 5: underflow sets a sticky error.
    nxt(); wb(3); step();
    nxt(); step();
    nxt(); cons(3); step();

    // 6: zero register is never tracked; then a 4-cycle stall on rd=10.
    nxt(); prod(ZR); step();
    nxt(); cons(ZR); ID_rt = 5'(ZR); ID_rt_used = 1'b1; step();
    nxt(); prod(10); step();
    for (int i = 0; i < 4; i++) begin nxt(); ID_valid = 1'b1; ID_rt = 5'd10; ID_rt_used = 1'b1; step(); end
    nxt(); cons(10); wb(10); step();

    // Mid-operation reset clears tracking immediately.
    nxt(); prod(12); step();
    nxt(); rst = 1'b1; cons(12); step();
    nxt(); rst = 1'b0; cons(12); step();

    // Random traffic over a small register pool.
    for (int i = 0; i < 800; i++) begin
      nxt();
      rst         = ($urandom_range(0, 199) == 0);
      ID_valid    = ($urandom_range(0, 3) != 0);
      ID_rs       = 5'(pick());
      ID_rt       = 5'(pick());
      ID_rs_used  = $urandom_range(0, 1) == 1;
      ID_rt_used  = $urandom_range(0, 1) == 1;
      ID_rd       = 5'(pick());
      ID_RegWrite = ($urandom_range(0, 3) != 0);
      ID_Track    = $urandom_range(0, 1) == 1;
      WB_rd       = 5'(pick());
      WB_RegWrite = ($urandom_range(0, 2) != 0);
      WB_Track    = ($urandom_range(0, 2) != 0);
      step();
    end

    nxt(); rst = 1'b0; step();
    @(negedge clk);
    #5;
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
